// File: rtl/imem_loader_pkg.sv
// Shared types for the instruction-memory loader: FSM encoding, default frame
// marker and bytes-per-word derivation.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CNT_HI = 3'd1,
    ST_CNT_LO = 3'd2,
    ST_WORD   = 3'd3,
    ST_CHK    = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  function automatic int bpw_of(input int instr_width);
    return instr_width / 8;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// master = loader side, slave = byte source / memory side.
interface imem_loader_if #(
  parameter int PC_WIDTH    = 16,
  parameter int INSTR_WIDTH = 32
);
  logic [7:0]             rx_data;
  logic                   rx_valid;
  logic                   rx_ready;
  logic                   imem_we;
  logic [PC_WIDTH-1:0]    imem_addr;
  logic [INSTR_WIDTH-1:0] imem_data;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, imem_we, imem_addr, imem_data
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, imem_we, imem_addr, imem_data
  );
endinterface

// File: rtl/loader_word_asm.sv
// Big-endian byte-to-word assembler; word_full flags the byte that completes a word
// (combinational), with word_o already including that byte.
module loader_word_asm
  import imem_loader_pkg::*;
#(
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   shift_en,
  input  logic [7:0]             byte_in,
  output logic [INSTR_WIDTH-1:0] word_o,
  output logic                   word_full
);

  localparam int BPW  = bpw_of(INSTR_WIDTH);
  localparam int IDXW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(BPW - 1);

  logic [INSTR_WIDTH-1:0] word_q, word_d;
  logic [IDXW-1:0]        idx_q, idx_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

  always_comb begin
    word_o    = (word_q << 8) | INSTR_WIDTH'(byte_in);
    word_full = shift_en && (idx_q == LAST_IDX);
    word_d    = word_q;
    idx_d     = idx_q;
    if (start) begin
      word_d = '0;
      idx_d  = '0;
    end else if (shift_en) begin
      word_d = word_o;
      idx_d  = word_full ? '0 : idx_q + 1'b1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Framed program-image loader: SYNC, 16-bit word count, payload, XOR checksum.
// Optional idle timeout enabled by macro LOADER_TIMEOUT_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         PC_WIDTH    = 16,
  parameter int         INSTR_WIDTH = 32,
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEFAULT
) (
  input  logic          clk,
  input  logic          RST,
  imem_loader_if.master bus,
  output logic          core_rst,
  output logic          done,
  output logic          err
);

  localparam logic [32:0] MAX_WORDS = 33'd1 << PC_WIDTH;

  state_t                 state_q, state_d;
  logic                   rx_ready_q;
  logic [15:0]            count_q, count_d;
  logic [7:0]             chk_q, chk_d;
  logic [16:0]            words_q, words_d;
  logic [PC_WIDTH-1:0]    addr_q, addr_d;
  logic [INSTR_WIDTH-1:0] data_q, data_d;
  logic                   we_q, we_d;

  logic                   accept;
  logic                   asm_start;
  logic                   asm_shift;
  logic                   word_full;
  logic [INSTR_WIDTH-1:0] asm_word;
  logic [15:0]            n_new;

`ifdef LOADER_TIMEOUT_EN
  logic [15:0] idle_q, idle_d;
  logic        active;
`endif

  assign accept = bus.rx_valid && rx_ready_q;

  loader_word_asm #(.INSTR_WIDTH(INSTR_WIDTH)) u_asm (
    .clk       (clk),
    .rst       (RST),
    .start     (asm_start),
    .shift_en  (asm_shift),
    .byte_in   (bus.rx_data),
    .word_o    (asm_word),
    .word_full (word_full)
  );

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      rx_ready_q <= 1'b0;
      count_q    <= '0;
      chk_q      <= '0;
      words_q    <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      we_q       <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
      idle_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rx_ready_q <= 1'b1;
      count_q    <= count_d;
      chk_q      <= chk_d;
      words_q    <= words_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      we_q       <= we_d;
`ifdef LOADER_TIMEOUT_EN
      idle_q     <= idle_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    chk_d     = chk_q;
    words_d   = words_q;
    addr_d    = addr_q;
    data_d    = data_q;
    we_d      = 1'b0;
    asm_start = 1'b0;
    asm_shift = 1'b0;
    n_new     = {count_q[15:8], bus.rx_data};

    // Address advances the cycle after each write pulse.
    if (we_q) addr_d = addr_q + 1'b1;

    if (accept) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.rx_data == SYNC_BYTE) state_d = ST_CNT_HI;
        end
        ST_CNT_HI: begin
          count_d[15:8] = bus.rx_data;
          chk_d         = bus.rx_data;
          state_d       = ST_CNT_LO;
        end
        ST_CNT_LO: begin
          count_d = n_new;
          chk_d   = chk_q ^ bus.rx_data;
          words_d = '0;
          if (n_new == 16'd0) begin
            state_d = ST_CHK;
          end else if ({17'd0, n_new} > MAX_WORDS) begin
            state_d = ST_ERR;
          end else begin
            state_d   = ST_WORD;
            addr_d    = '0;
            asm_start = 1'b1;
          end
        end
        ST_WORD: begin
          chk_d     = chk_q ^ bus.rx_data;
          asm_shift = 1'b1;
          if (word_full) begin
            we_d    = 1'b1;
            data_d  = asm_word;
            words_d = words_q + 17'd1;
            if (words_q + 17'd1 == {1'b0, count_q}) state_d = ST_CHK;
          end
        end
        ST_CHK: begin
          state_d = (bus.rx_data == chk_q) ? ST_DONE : ST_ERR;
        end
        ST_DONE, ST_ERR: begin
          if (bus.rx_data == SYNC_BYTE) state_d = ST_CNT_HI;
        end
        default: state_d = ST_IDLE;
      endcase
    end

`ifdef LOADER_TIMEOUT_EN
    active = (state_q == ST_CNT_HI) || (state_q == ST_CNT_LO) ||
             (state_q == ST_WORD)   || (state_q == ST_CHK);
    idle_d = '0;
    if (active && !accept) begin
      idle_d = idle_q + 16'd1;
      if (idle_q == 16'hFFFF) state_d = ST_ERR;
    end
`endif
  end

  always_comb begin
    bus.rx_ready  = rx_ready_q;
    bus.imem_we   = we_q;
    bus.imem_addr = addr_q;
    bus.imem_data = data_q;
    core_rst      = (state_q != ST_DONE);
    done          = (state_q == ST_DONE);
    err           = (state_q == ST_ERR);
  end

endmodule
